// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared state encoding and default width for the iterative multiplier
package seq_multiplier_pkg;
  localparam int WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_multiplier_add_step.sv
// mult_add_step: one shift-add iteration (conditional accumulate, shift multiplicand and multiplier)
module mult_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  always_comb begin
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency shift-add unsigned multiplier, one multiplier bit per clock
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [CW-1:0] count;
  logic load, last;
  mult_add_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .mcand(mcand),
    .mplier(mplier),
    .acc_nxt(acc_nxt),
    .mcand_nxt(mcand_nxt),
    .mplier_nxt(mplier_nxt)
  );
  always_comb begin
    load      = start && (state == S_IDLE || state == S_DONE);
    last      = state == S_RUN && count == CW'(WIDTH - 1);
    state_nxt = load ? S_RUN : state == S_RUN ? (last ? S_DONE : S_RUN) : S_IDLE;
    busy      = state == S_RUN;
    done      = state == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        count  <= '0;
      end else if (state == S_RUN) begin
        acc    <= acc_nxt;
        mcand  <= mcand_nxt;
        mplier <= mplier_nxt;
        count  <= count + 1'b1;
      end
      // the final sum bypasses acc so the result is visible together with done
      if (last) begin
        product  <= acc_nxt[WIDTH-1:0];
        overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic busy, done, overflow;
  logic [31:0] product;
  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, output logic [31:0] p,
                        output logic o, output int lat, output int nbusy);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    for (int c = 1; c <= 100; c++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    p = product;
    o = overflow;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overflow, product} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b product=%h, required all zero", busy, done, overflow, product);
    end
    reset = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] ep, input logic eo);
    logic [31:0] p;
    logic o;
    int lat, nbusy;
    do_mul(x, y, p, o, lat, nbusy);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL %s_latency: done at cycle %0d, required 33", name, lat);
    end
    checks++;
    if (nbusy !== 32) begin
      errors++;
      $display("FAIL %s_busy: busy for %0d cycles, required 32", name, nbusy);
    end
    checks++;
    if (p !== ep || o !== eo) begin
      errors++;
      $display("FAIL %s_result: product=%h ovf=%b, required product=%h ovf=%b", name, p, o, ep, eo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b busy=%b after done, required 0/0", name, done, busy);
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    @(negedge clk);
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 10) begin
        start = 1'b1;
        a = 32'd100;
        b = 32'd77;
      end else if (c == 11) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL ignore_start_latency: done at cycle %0d, required 33", lat);
    end
    checks++;
    if (product !== 32'd15 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result: product=%0d ovf=%b, required 15/0", product, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    int unstable = 0;
    @(negedge clk);
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 150; c++) begin
      if (done && first == 0) begin
        first = c;
        checks++;
        if (product !== 32'd6) begin
          errors++;
          $display("FAIL b2b_first_result: product=%0d, required 6", product);
        end
        a = 32'd4;
        b = 32'd5;
      end else if (done) begin
        second = c;
        break;
      end else if (first != 0 && product !== 32'd6) unstable++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (first !== 33 || second !== 66) begin
      errors++;
      $display("FAIL b2b_timing: done at %0d and %0d, required 33 and 66", first, second);
    end
    checks++;
    if (product !== 32'd20) begin
      errors++;
      $display("FAIL b2b_second_result: product=%0d, required 20", product);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL b2b_hold: product changed in %0d cycles between results, required 0", unstable);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int spurious = 0;
    @(negedge clk);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b product=%h ovf=%b, required 0/0/0/0", busy, done, product, overflow);
    end
    for (int c = 0; c < 40; c++) begin
      if (done || busy) spurious++;
      @(negedge clk);
    end
    checks++;
    if (spurious !== 0 || product !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_done: %0d active cycles, product=%h, required 0 and 0", spurious, product);
    end
  endtask

  initial begin
    test_reset();
    test_vector("basic", 32'd6, 32'd7, 32'd42, 1'b0);
    test_vector("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    test_vector("b_zero", 32'h12345678, 32'd0, 32'd0, 1'b0);
    test_vector("a_zero", 32'd0, 32'd5, 32'd0, 1'b0);
    test_vector("b_ones", 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_vector("ovf_exact", 32'h00010000, 32'h00010000, 32'd0, 1'b1);
    test_vector("max_fit", 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
